// File: rtl/mem_bist_pkg.sv
// mem_bist_pkg: shared types, pattern-select codes and the data-pattern
// function for the memory BIST master.
//   bist_state_e  - run states of the master FSM
//   PAT_*         - pattern_sel_i encodings
//   bist_pattern  - expected data word for (addr, sel), truncated to width
package mem_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    localparam logic [1:0] PAT_CHECKER = 2'd0;
    localparam logic [1:0] PAT_ADDR    = 2'd1;
    localparam logic [1:0] PAT_NADDR   = 2'd2;
    localparam logic [1:0] PAT_ONES    = 2'd3;

    // Widest data word the pattern function can produce.
    localparam int PAT_MAX_W = 64;

    // addr arrives zero-extended; the result is masked to 'width' bits so that
    // ~addr and all-ones come out correctly for any data width.
    function automatic logic [PAT_MAX_W-1:0] bist_pattern(
        input logic [PAT_MAX_W-1:0] addr,
        input logic [1:0]           sel,
        input int                   width
    );
        logic [PAT_MAX_W-1:0] mask;
        logic [PAT_MAX_W-1:0] res;
        if (width >= PAT_MAX_W) begin
            mask = '1;
        end else begin
            mask = (64'd1 << width) - 64'd1;
        end
        case (sel)
            PAT_CHECKER: res = addr[0] ? {32{2'b01}} : {32{2'b10}};
            PAT_ADDR:    res = addr;
            PAT_NADDR:   res = ~addr;
            default:     res = '1;
        endcase
        return res & mask;
    endfunction

endpackage

// File: rtl/mem_bist_pattern_gen.sv
// mem_bist_pattern_gen: combinational expected-data generator.
//   addr_i  - memory address
//   sel_i   - pattern select (PAT_*)
//   data_o  - pattern word for that address
module mem_bist_pattern_gen
    import mem_bist_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [1:0]            sel_i,
    output logic [WIDTH-1:0]      data_o
);

    assign data_o = WIDTH'(bist_pattern(PAT_MAX_W'(addr_i), sel_i, WIDTH));

endmodule

// File: rtl/mem_bist_master.sv
// mem_bist_master: write-then-read-back BIST driving a valid/ready memory port.
// On start, writes the selected pattern to every address, reads them all back,
// and reports pass/fail, mismatch count and first failing address.
// Optional macro BIST_TIMEOUT_EN: abort a run if one request stalls for
// TIMEOUT_CYCLES cycles (timeout_o = 1, pass_o = 0).
// Ports:
//   clk_i, rst_i (sync, active-low)
//   start_i, pattern_sel_i                       - run control
//   busy_o, done_o, pass_o, err_count_o,
//   fail_addr_o, timeout_o                       - status / results
//   addr_o, wdata_o, wr_rd_o, valid_o            - memory request
//   rdata_i, ready_i                             - memory response
//
// state | meaning
// IDLE  | waiting for start after reset
// WRITE | writing pattern(addr) to addr 0..DEPTH-1
// READ  | reading addr 0..DEPTH-1 and comparing
// DONE  | results valid and held until next start
module mem_bist_master
    import mem_bist_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int DEPTH          = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [1:0]            pattern_sel_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ADDR_WIDTH:0]   err_count_o,
    output logic [ADDR_WIDTH-1:0] fail_addr_o,
    output logic                  timeout_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  wr_rd_o,
    output logic                  valid_o,
    input  logic [WIDTH-1:0]      rdata_i,
    input  logic                  ready_i
);

    if (ADDR_WIDTH != $clog2(DEPTH) || WIDTH > PAT_MAX_W || TIMEOUT_CYCLES < 1) begin : g_param_chk
        $error("mem_bist_master: illegal parameter combination");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ERR_MAX   = (ADDR_WIDTH + 1)'(DEPTH);

    bist_state_e           state_q;
    logic [1:0]            pat_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic                  wr_rd_q;
    logic                  valid_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  pass_q;
    logic [ADDR_WIDTH:0]   err_q;
    logic [ADDR_WIDTH-1:0] fail_q;
    logic                  timeout_q;

    logic                  start_ok;
    logic                  xfer;
    logic                  last;
    logic                  mismatch;
    logic                  tmo_hit;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [1:0]            sel_d;
    logic [WIDTH-1:0]      wdata_d;
    logic [WIDTH-1:0]      exp_cur;
    logic [ADDR_WIDTH:0]   err_inc;

    assign start_ok = start_i && (state_q == ST_IDLE || state_q == ST_DONE);
    assign xfer     = valid_q && ready_i;
    assign last     = (addr_q == LAST_ADDR);
    assign mismatch = (rdata_i != exp_cur);
    assign err_inc  = (err_q == ERR_MAX) ? err_q : err_q + 1'b1;
    assign sel_d    = start_ok ? pattern_sel_i : pat_q;

    // Address of the request presented next cycle; write data is precomputed
    // from it so wdata_o is a clean register.
    always_comb begin
        addr_d = addr_q;
        if (start_ok) begin
            addr_d = '0;
        end else if (xfer) begin
            if (!last) begin
                addr_d = addr_q + 1'b1;
            end else if (state_q == ST_WRITE) begin
                addr_d = '0;
            end
        end
    end

    mem_bist_pattern_gen #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_gen_next (
        .addr_i (addr_d),
        .sel_i  (sel_d),
        .data_o (wdata_d)
    );

    mem_bist_pattern_gen #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_gen_cmp (
        .addr_i (addr_q),
        .sel_i  (pat_q),
        .data_o (exp_cur)
    );

`ifdef BIST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            tcnt_q <= '0;
        end else if (start_ok || xfer) begin
            tcnt_q <= '0;
        end else if (valid_q && !ready_i) begin
            tcnt_q <= tcnt_q + 1'b1;
        end
    end

    // Fires on the stall cycle that brings the count to TIMEOUT_CYCLES.
    assign tmo_hit = valid_q && !ready_i && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_rd_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            fail_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        state_q   <= ST_WRITE;
                        pat_q     <= pattern_sel_i;
                        addr_q    <= addr_d;
                        wdata_q   <= wdata_d;
                        wr_rd_q   <= 1'b1;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        err_q     <= '0;
                        fail_q    <= '0;
                        timeout_q <= 1'b0;
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (xfer) begin
                        addr_q  <= addr_d;
                        wdata_q <= wdata_d;
                        if (state_q == ST_WRITE) begin
                            if (last) begin
                                state_q <= ST_READ;
                                wr_rd_q <= 1'b0;
                            end
                        end else begin
                            if (mismatch) begin
                                err_q <= err_inc;
                                if (err_q == '0) begin
                                    fail_q <= addr_q;
                                end
                            end
                            if (last) begin
                                state_q <= ST_DONE;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                                // Final compare is folded in here since err_q
                                // has not yet absorbed it.
                                pass_q  <= !mismatch && (err_q == '0);
                            end
                        end
                    end else if (tmo_hit) begin
                        state_q   <= ST_DONE;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        pass_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign err_count_o = err_q;
    assign fail_addr_o = fail_q;
    assign timeout_o   = timeout_q;
    assign addr_o      = addr_q;
    assign wdata_o     = wdata_q;
    assign wr_rd_o     = wr_rd_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_mem_bist_master.sv
module tb_mem_bist_master;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int AW = 4;
`ifdef BIST_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [1:0]    pattern_sel_i = '0;
    logic          busy_o, done_o, pass_o, timeout_o, wr_rd_o, valid_o;
    logic [AW:0]   err_count_o;
    logic [AW-1:0] fail_addr_o, addr_o;
    logic [W-1:0]  wdata_o;
    logic [W-1:0]  rdata_i = '0;
    logic          ready_i = 1'b0;

    mem_bist_master #(.WIDTH(W), .DEPTH(D), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .pattern_sel_i (pattern_sel_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .pass_o        (pass_o),
        .err_count_o   (err_count_o),
        .fail_addr_o   (fail_addr_o),
        .timeout_o     (timeout_o),
        .addr_o        (addr_o),
        .wdata_o       (wdata_o),
        .wr_rd_o       (wr_rd_o),
        .valid_o       (valid_o),
        .rdata_i       (rdata_i),
        .ready_i       (ready_i)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    // memory model + fault configuration
    logic [W-1:0] mem [D];
    logic [D-1:0] fault_mask = '0;
    int           fault_bit  = 0;
    bit           fault_val  = 1'b1;
    int           delay      = 0;
    bit           never_ready = 1'b0;
    int           wait_cnt   = 0;

    // monitor
    bit           mon_en = 1'b0;
    int           cur_pat = 0;
    int           valid_cycles, n_wr, n_rd, seq_err, hs_err;
    logic [W-1:0] wd_at5;
    logic         prev_v = 1'b0, prev_r = 1'b0, prev_w = 1'b0;
    logic [AW-1:0] prev_a = '0;
    logic [W-1:0] prev_d = '0;

    function automatic logic [W-1:0] ref_pat(input int sel, input int a);
        case (sel)
            0:       return (a % 2 == 0) ? 16'hAAAA : 16'h5555;
            1:       return 16'(a);
            2:       return 16'(65535 - a);
            default: return 16'hFFFF;
        endcase
    endfunction

    function automatic logic [W-1:0] faulty(input int a, input logic [W-1:0] d);
        logic [W-1:0] bm;
        bm = 16'(1 << fault_bit);
        if (!fault_mask[a]) return d;
        return fault_val ? (d | bm) : (d & ~bm);
    endfunction

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // ready/rdata are driven mid-cycle, after the DUT outputs have settled
    always @(negedge clk_i) begin
        if (valid_o && !never_ready && wait_cnt >= delay) begin
            ready_i  = 1'b1;
            wait_cnt = 0;
        end else begin
            ready_i  = 1'b0;
            wait_cnt = valid_o ? wait_cnt + 1 : 0;
        end
        rdata_i = faulty(int'(addr_o), mem[addr_o]);
        if (ready_i && valid_o && wr_rd_o) mem[addr_o] = wdata_o;
        if (mon_en) begin
            if (valid_o) valid_cycles++;
            if (valid_o && ready_i) begin
                if (wr_rd_o) begin
                    if (int'(addr_o) != n_wr || wdata_o != ref_pat(cur_pat, int'(addr_o))) seq_err++;
                    if (addr_o == 4'd5) wd_at5 = wdata_o;
                    n_wr++;
                end else begin
                    if (int'(addr_o) != n_rd) seq_err++;
                    n_rd++;
                end
            end
            if (prev_v && !prev_r) begin
                if (!valid_o) begin
                    if (!timeout_o) hs_err++;
                end else if (addr_o != prev_a || wdata_o != prev_d || wr_rd_o != prev_w) begin
                    hs_err++;
                end
            end
        end
        prev_v = valid_o; prev_r = ready_i; prev_a = addr_o; prev_d = wdata_o; prev_w = wr_rd_o;
    end

    task automatic clear_mon();
        valid_cycles = 0; n_wr = 0; n_rd = 0; seq_err = 0; hs_err = 0; wd_at5 = '0;
        mon_en = 1'b1;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done_o && n < 2000) begin
            tick();
            n++;
        end
        if (!done_o) check({nm, "_done_timeout"}, 0, 1);
    endtask

    task automatic do_run(input int pat, input int dly);
        cur_pat = pat;
        delay = dly;
        clear_mon();
        pattern_sel_i = 2'(pat);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
        wait_done("run");
    endtask

    function automatic void model_expect(input int pat, output int e_err, output int e_fail);
        e_err = 0;
        e_fail = 0;
        for (int a = 0; a < D; a++) begin
            logic [W-1:0] ex;
            ex = ref_pat(pat, a);
            if (faulty(a, ex) != ex) begin
                if (e_err == 0) e_fail = a;
                e_err++;
            end
        end
        if (e_err > D) e_err = D;
    endfunction

    typedef struct {
        int pat;
        int dly;
        bit fault;
        bit exp_pass;
        int exp_err;
        int exp_fail;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int e_err, e_fail;
        vecs[0] = '{pat: 1, dly: 0, fault: 0, exp_pass: 1, exp_err: 0, exp_fail: 0};
        vecs[1] = '{pat: 0, dly: 3, fault: 0, exp_pass: 1, exp_err: 0, exp_fail: 0};
        vecs[2] = '{pat: 3, dly: 0, fault: 1, exp_pass: 1, exp_err: 0, exp_fail: 0};
        vecs[3] = '{pat: 1, dly: 0, fault: 1, exp_pass: 0, exp_err: 1, exp_fail: 6};
        vecs[4] = '{pat: 2, dly: 1, fault: 1, exp_pass: 0, exp_err: 1, exp_fail: 9};
        vecs[5] = '{pat: 0, dly: 2, fault: 1, exp_pass: 0, exp_err: 1, exp_fail: 6};
        for (int a = 0; a < D; a++) mem[a] = '0;

        // reset state
        rst_i = 1'b0;
        tick(); tick();
        check("reset_outputs", {valid_o, wr_rd_o, addr_o, wdata_o, busy_o, done_o, pass_o,
                                err_count_o, fail_addr_o, timeout_o}, 0);
        rst_i = 1'b1;
        tick();
        check("idle_no_valid", valid_o, 0);

        // table-driven runs
        for (int i = 0; i < 6; i++) begin
            fault_mask = vecs[i].fault ? 16'h0240 : 16'h0000;
            fault_bit = 0;
            fault_val = 1'b1;
            do_run(vecs[i].pat, vecs[i].dly);
            check("vec_done", done_o, 1);
            check("vec_busy", busy_o, 0);
            check("vec_valid_low", valid_o, 0);
            check("vec_pass", pass_o, vecs[i].exp_pass);
            check("vec_err", err_count_o, vecs[i].exp_err);
            check("vec_fail_addr", fail_addr_o, vecs[i].exp_fail);
            check("vec_timeout", timeout_o, 0);
            check("vec_sequence", seq_err, 0);
            check("vec_stall_stable", hs_err, 0);
            check("vec_valid_cycles", valid_cycles, 32 * (vecs[i].dly + 1));
            if (vecs[i].pat == 0) check("write_addr5_data", wd_at5, 16'h5555);
            tick();
            check("vec_result_hold", {done_o, pass_o, err_count_o}, {1'b1, vecs[i].exp_pass, 5'(vecs[i].exp_err)});
        end

        // reset in the middle of the write phase
        fault_mask = '0;
        cur_pat = 1; delay = 0; clear_mon();
        pattern_sel_i = 2'd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        begin
            int n = 0;
            while (!(valid_o && wr_rd_o && addr_o == 4'd6) && n < 100) begin
                tick();
                n++;
            end
            check("reach_7th_write", addr_o, 6);
        end
        mon_en = 1'b0;
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        check("midrun_reset_outputs", {valid_o, wr_rd_o, addr_o, wdata_o, busy_o, done_o, pass_o,
                                       err_count_o, fail_addr_o, timeout_o}, 0);
        tick(); tick();
        check("midrun_reset_idle", {valid_o, busy_o, done_o}, 0);
        do_run(1, 0);
        check("post_reset_pass", pass_o, 1);
        check("post_reset_sequence", seq_err, 0);

        // start held high: back-to-back runs
        fault_mask = 16'h0240; fault_bit = 0; fault_val = 1'b1;
        mon_en = 1'b0;
        pattern_sel_i = 2'd1;
        start_i = 1'b1;
        tick();
        wait_done("held1");
        check("held_run1_err", err_count_o, 1);
        check("held_run1_fail", fail_addr_o, 6);
        tick();
        check("held_done_one_cycle", done_o, 0);
        check("held_restart_busy", busy_o, 1);
        check("held_err_cleared", err_count_o, 0);
        check("held_fail_cleared", fail_addr_o, 0);
        start_i = 1'b0;
        wait_done("held2");
        check("held_run2_err", err_count_o, 1);
        tick(); tick();
        check("held_stays_done", {done_o, busy_o}, 2'b10);

`ifdef BIST_TIMEOUT_EN
        // memory never answers
        fault_mask = '0;
        never_ready = 1'b1;
        cur_pat = 1; delay = 0; clear_mon();
        pattern_sel_i = 2'd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        begin
            int n = 0;
            while (valid_o && n < 200) begin
                tick();
                n++;
            end
            check("tmo_valid_dropped", valid_o, 0);
        end
        tick();
        check("tmo_valid_cycles", valid_cycles, TMO);
        check("tmo_flag", timeout_o, 1);
        check("tmo_done", done_o, 1);
        check("tmo_pass", pass_o, 0);
        check("tmo_err_kept", err_count_o, 0);
        check("tmo_handshake", hs_err, 0);
        never_ready = 1'b0;
        tick();
`endif

        // random runs against the reference model
        for (int r = 0; r < 16; r++) begin
            int p, dl;
            p = int'($urandom_range(0, 3));
            dl = int'($urandom_range(0, 2));
            fault_mask = 16'($urandom);
            fault_bit = int'($urandom_range(0, W - 1));
            fault_val = 1'($urandom);
            model_expect(p, e_err, e_fail);
            do_run(p, dl);
            check("rnd_pass", pass_o, (e_err == 0) ? 1 : 0);
            check("rnd_err", err_count_o, e_err);
            check("rnd_fail_addr", fail_addr_o, e_fail);
            check("rnd_sequence", seq_err, 0);
            check("rnd_stall_stable", hs_err, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
